ets_frame_writer: RTL and testbench
===================================

// Module: ets_frame_writer
// PURPOSE
//  Multi-channel successor to the single-channel ETS write sequencer.
//  - Accepts one ETS sample step per valid/ready 4-phase handshake from NUM_CH ETS cores.
//  - Writes each step into the current write buffer at a running tap address.
//  - After DEPTH taps, requests a triple-buffer swap and waits for frame_ready.
//  - Sits between the ETS cores and the triple-buffer controller/RAMs, in the shifting-clock domain.
// PARAMETERS
//  NUM_CH      2     channels written in parallel, sharing one address
//  DATA_W      32    sample word width per channel
//  DEPTH       2240  taps per frame; addresses 0..DEPTH-1; must be >=2
//  ADDR_W      12    address width; 2**ADDR_W >= DEPTH
//  WR_HOLD     2     cycles wr_we is held per tap (RAM write hold); >=1
//  TIMEOUT_CYC 4096  REQUEST-wait limit, used only with ETS_FRAME_TIMEOUT_EN
// PORTS
//  clk          in   1               shifting clock; all logic on rising edge
//  reset        in   1               synchronous, active-high
//  en           in   1               allow new taps to start
//  ch_en        in   NUM_CH          channel write mask, sampled at frame start
//  s_valid      in   1               core sample valid (level, 4-phase)
//  s_ready      out  1               tap committed; held until s_valid falls
//  s_data       in   NUM_CH*DATA_W   samples; ch0 occupies the LSBs
//  wr_addr      out  ADDR_W          RAM write address
//  wr_data      out  NUM_CH*DATA_W   registered copy of s_data
//  wr_we        out  NUM_CH          per-channel RAM write enable
//  frame_req    out  1               buffer-swap request to the controller
//  frame_ready  in   1               controller swap acknowledge
//  frame_count  out  16              completed frames, wraps at 16 bits
//  busy         out  1               high whenever state != IDLE
//  timeout_err  out  1               sticky flag; tied 0 without the macro
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE, wr_addr 0, mask register 0, timeout counter 0.
//  - States:
//    - IDLE: on en&&s_valid, go to WRITE, load wr_data<=s_data and hold cnt<=0.
//      If wr_addr==0, also latch mask<=ch_en. With en low, stay in IDLE.
//    - WRITE: wr_we=mask for WR_HOLD cycles, with wr_addr and wr_data stable. On the last cycle:
//      - if wr_addr==DEPTH-1: wr_addr<=0, go to REQUEST;
//      - else: wr_addr<=wr_addr+1, go to DONE.
//    - REQUEST: frame_req=1. On the first cycle frame_ready=1, frame_count+1 and go to DONE.
//    - DONE: s_ready=1. When s_valid=0, go to IDLE. s_ready falls in the same cycle the state leaves DONE.
//  - Latency: s_valid rise -> first wr_we = 1 clk; s_valid rise -> s_ready = WR_HOLD+1 clks (no frame end).
//  - All-zero mask: full sequencing still runs with wr_we=0 and the address still advances.
//  - en falling mid-tap does not abort it; the tap and any pending REQUEST complete.
//  - frame_ready already high on REQUEST entry: request lasts exactly 1 cycle.
//  - frame_ready outside REQUEST is ignored.
//  - s_valid dropping before DONE: ignored until DONE; DONE then exits on its first cycle.
//  - reset mid-frame: partial frame discarded, wr_addr 0, no request, frame_count 0.
//  - Unused state encodings return to IDLE.
// CONFIGURATION
//  ETS_FRAME_TIMEOUT_EN defined:
//  - Counts REQUEST cycles. After TIMEOUT_CYC cycles without frame_ready:
//    - drop the frame: frame_req falls, frame_count unchanged;
//    - set timeout_err (cleared only by reset);
//    - go to DONE.
//  - The counter clears on REQUEST entry.
//  ETS_FRAME_TIMEOUT_EN undefined: REQUEST waits indefinitely; timeout_err constant 0; no counter.
// TESTING
//  1. Reset, then one s_valid pulse with ch_en=2'b11 and s_data={32'hB,32'hA}:
//     -> wr_we=11 for 2 clks at addr 0 with data {B,A}; s_ready at clk 3; wr_addr=1 afterwards.
//  2. DEPTH=4; 4 taps with frame_ready tied 1:
//     -> frame_req for 1 clk after tap 4; frame_count=1; wr_addr=0.
//  3. ch_en=01 at frame start, changed to 10 mid-frame:
//     -> wr_we=01 for the whole frame, 10 from the next frame.
//  4. frame_ready held 0 for 50 clks after the last tap, then 1:
//     -> frame_req high for 51 clks; s_ready only afterwards; frame_count+1.
//  5. With the macro, TIMEOUT_CYC=8, frame_ready stuck at 0:
//     -> frame_req drops after 8 clks; timeout_err=1; frame_count unchanged; next tap writes addr 0.
//  6. reset asserted during WRITE of tap 2:
//     -> next clk: wr_we=0, wr_addr=0, busy=0, frame_count=0.

Source files
------------

// File: rtl/ets_frame_writer.sv
// ets_frame_writer
//   Multi-channel ETS write sequencer. Takes one sample step per 4-phase
//   valid/ready handshake, writes all NUM_CH channels at a shared running tap
//   address, and after DEPTH taps requests a triple-buffer swap.
//
//   Optional feature macro: ETS_FRAME_TIMEOUT_EN
//     defined   -> REQUEST gives up after TIMEOUT_CYC cycles without
//                  frame_ready, drops the frame and sets sticky timeout_err.
//     undefined -> REQUEST waits indefinitely; timeout_err is constant 0.
//
// Ports
//   clk          shifting clock, rising edge
//   reset        synchronous, active-high
//   en           allows a new tap to start
//   ch_en        channel write mask, latched at frame start (tap address 0)
//   s_valid      core sample valid (level)
//   s_ready      tap committed; held until s_valid falls
//   s_data       NUM_CH samples, ch0 in the LSBs
//   wr_addr      RAM write address (running tap index)
//   wr_data      registered copy of s_data
//   wr_we        per-channel RAM write enable
//   frame_req    buffer-swap request
//   frame_ready  swap acknowledge (only looked at in REQUEST)
//   frame_count  completed frames, wraps at 16 bits
//   busy         high whenever the sequencer is not idle
//   timeout_err  sticky request-timeout flag
module ets_frame_writer #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 2240,
  parameter int ADDR_W      = 12,
  parameter int WR_HOLD     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0]        wr_we,
  output logic                     frame_req,
  input  logic                     frame_ready,
  output logic [15:0]              frame_count,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_REQUEST = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int CNT_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_CH-1:0]  mask_r;

`ifdef ETS_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]    to_cnt_r;
`endif

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      mask_r      <= '0;
      s_ready     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_we       <= '0;
      frame_req   <= 1'b0;
      frame_count <= 16'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef ETS_FRAME_TIMEOUT_EN
      to_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (en && s_valid) begin
            state_r <= S_WRITE;
            busy    <= 1'b1;
            wr_data <= s_data;
            cnt_r   <= '0;
            // The mask only changes at a frame boundary so a frame is
            // always written with one consistent channel set.
            if (wr_addr == '0) begin
              mask_r <= ch_en;
              wr_we  <= ch_en;
            end else begin
              wr_we  <= mask_r;
            end
          end
        end
        S_WRITE: begin
          if (cnt_r == CNT_W'(WR_HOLD - 1)) begin
            wr_we <= '0;
            if (wr_addr == ADDR_W'(DEPTH - 1)) begin
              wr_addr   <= '0;
              frame_req <= 1'b1;
              state_r   <= S_REQUEST;
`ifdef ETS_FRAME_TIMEOUT_EN
              to_cnt_r  <= '0;
`endif
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
              s_ready <= 1'b1;
              state_r <= S_DONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_REQUEST: begin
          if (frame_ready) begin
            frame_req   <= 1'b0;
            frame_count <= frame_count + 16'd1;
            s_ready     <= 1'b1;
            state_r     <= S_DONE;
`ifdef ETS_FRAME_TIMEOUT_EN
          end else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
            // Controller never answered: drop the frame, keep the count.
            frame_req   <= 1'b0;
            timeout_err <= 1'b1;
            s_ready     <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            to_cnt_r    <= to_cnt_r + TO_W'(1);
`endif
          end
        end
        S_DONE: begin
          if (!s_valid) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          s_ready   <= 1'b0;
          wr_we     <= '0;
          frame_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ets_frame_writer.sv
// tb_ets_frame_writer
//   Directed bench for ets_frame_writer with DEPTH=4, WR_HOLD=2, TIMEOUT_CYC=8.
//   Expected RAM writes are queued when a tap is driven and compared by a
//   monitor when wr_we rises; handshake, frame and reset behaviour are
//   compared against a small reference model kept in the stimulus block.
module tb_ets_frame_writer;

  localparam int NUM_CH      = 2;
  localparam int DATA_W      = 32;
  localparam int DEPTH       = 4;
  localparam int ADDR_W      = 12;
  localparam int WR_HOLD     = 2;
  localparam int TIMEOUT_CYC = 8;

  typedef struct packed {
    logic [ADDR_W-1:0]        addr;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        we;
  } wr_t;

  logic                     clk;
  logic                     reset;
  logic                     en;
  logic [NUM_CH-1:0]        ch_en;
  logic                     s_valid;
  logic                     s_ready;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [ADDR_W-1:0]        wr_addr;
  logic [NUM_CH*DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0]        wr_we;
  logic                     frame_req;
  logic                     frame_ready;
  logic [15:0]              frame_count;
  logic                     busy;
  logic                     timeout_err;

  int total = 0;
  int bad   = 0;

  wr_t exp_q[$];
  wr_t mon_e;
  int  mon_run = 0;

  // reference model state
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [NUM_CH-1:0] m_mask  = '0;
  logic [15:0]       m_count = 16'd0;
  logic              m_terr  = 1'b0;

  ets_frame_writer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .WR_HOLD(WR_HOLD), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ch_en(ch_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_we(wr_we),
    .frame_req(frame_req), .frame_ready(frame_ready),
    .frame_count(frame_count), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: compares each burst of wr_we against the queued tap and
  // checks the burst length equals WR_HOLD.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_run = 0;
      end else if (wr_we != '0) begin
        if (mon_run == 0) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 64'(wr_we), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
            check("wr_data", wr_data, mon_e.data);
            check("wr_we", 64'(wr_we), 64'(mon_e.we));
          end
        end
        mon_run++;
      end else if (mon_run != 0) begin
        check("wr_hold", 64'(mon_run), 64'(WR_HOLD));
        mon_run = 0;
      end
    end
  end

  // One complete tap. rdy_after: 0 = frame_ready high, >0 = raise frame_ready
  // once frame_req has been seen that many cycles, <0 = never acknowledge.
  task automatic tap(input logic [63:0] d, input int rdy_after, input bit drop_en);
    int n, req, exp_req;
    bit fend;
    if (m_addr == '0) m_mask = ch_en;
    if (m_mask != '0) exp_q.push_back('{addr: m_addr, data: d, we: m_mask});
    fend = (m_addr == ADDR_W'(DEPTH - 1));
    exp_req = !fend ? 0 : (rdy_after == 0) ? 1 : (rdy_after > 0) ? rdy_after : TIMEOUT_CYC;
    if (fend && rdy_after != 0) frame_ready = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    req = 0;
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
      if (drop_en && n == 1) en = 1'b0;
      if (frame_req) req++;
      if (rdy_after > 0 && req == rdy_after) frame_ready = 1'b1;
    end
    check("s_ready_latency", 64'(n), 64'(WR_HOLD + 1 + exp_req));
    check("frame_req_cycles", 64'(req), 64'(exp_req));
    check("frame_req_low_at_ready", 64'(frame_req), 64'd0);
    if (fend) begin
      m_addr = '0;
      if (rdy_after >= 0) m_count = m_count + 16'd1;
      else m_terr = 1'b1;
    end else begin
      m_addr = m_addr + ADDR_W'(1);
    end
    check("frame_count", 64'(frame_count), 64'(m_count));
    check("wr_addr_after", 64'(wr_addr), 64'(m_addr));
    check("timeout_err", 64'(timeout_err), 64'(m_terr));
    s_valid = 1'b0;
    @(negedge clk);
    check("s_ready_fall", 64'(s_ready), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    frame_ready = 1'b1;
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; ch_en = 2'b11; s_valid = 1'b0;
    s_data = '0; frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_we", 64'(wr_we), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_frame_req", 64'(frame_req), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // frame 1: first tap {B,A}, frame_ready already high at the end
    tap({32'h0000_000B, 32'h0000_000A}, 0, 1'b0);
    for (int i = 1; i < DEPTH; i++) tap({$urandom, $urandom}, 0, 1'b0);

    // frame 2: mask 01 latched, changed mid-frame; slow acknowledge
    ch_en = 2'b01;
    tap({$urandom, $urandom}, 0, 1'b0);
    ch_en = 2'b10;
    tap({$urandom, $urandom}, 0, 1'b1);
    tap({$urandom, $urandom}, 0, 1'b0);
    tap({$urandom, $urandom}, 51, 1'b0);

    // frame 3: new mask 10 takes effect
    for (int i = 0; i < DEPTH; i++) tap({$urandom, $urandom}, 0, 1'b0);

    // en low holds the sequencer idle
    en = 1'b0;
    s_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("en_low_busy", 64'(busy), 64'd0);
    check("en_low_we", 64'(wr_we), 64'd0);
    check("en_low_addr", 64'(wr_addr), 64'(m_addr));
    s_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // frame 4: all-zero mask still sequences and counts
    ch_en = 2'b00;
    for (int i = 0; i < DEPTH; i++) tap({$urandom, $urandom}, 0, 1'b0);

`ifdef ETS_FRAME_TIMEOUT_EN
    // frame 5: controller never acknowledges
    ch_en = 2'b11;
    for (int i = 0; i < DEPTH - 1; i++) tap({$urandom, $urandom}, 0, 1'b0);
    tap({$urandom, $urandom}, -1, 1'b0);
    tap({$urandom, $urandom}, 0, 1'b0);
`endif

    // reset in the WRITE phase of tap 2 of a new frame
    ch_en = 2'b11;
    if (m_addr != '0) begin
      while (m_addr != '0) tap({$urandom, $urandom}, 0, 1'b0);
    end
    tap({$urandom, $urandom}, 0, 1'b0);
    s_data = {$urandom, $urandom};
    exp_q.push_back('{addr: m_addr, data: s_data, we: m_mask});
    s_valid = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check("midrst_wr_we", 64'(wr_we), 64'd0);
    check("midrst_wr_addr", 64'(wr_addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    check("midrst_frame_req", 64'(frame_req), 64'd0);
    check("midrst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;
    m_addr = '0; m_mask = '0; m_count = 16'd0; m_terr = 1'b0;
    @(negedge clk);

    // after reset the frame restarts at address 0 with a fresh mask
    ch_en = 2'b01;
    tap({32'h1234_5678, 32'h9ABC_DEF0}, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
